// File: rtl/key_conditioner_pkg.sv
// Shared types and default timing for the push-button conditioner.
//   key_state_t : per-key debounce / repeat FSM states
//   *_50M       : default cycle counts for a 50 MHz clock
package key_cond_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } key_state_t;

    localparam int unsigned NUM_KEYS_DEF = 3;
    localparam int unsigned DEBOUNCE_50M = 1_000_000;   // 20 ms
    localparam int unsigned HOLD_50M     = 25_000_000;  // 0.5 s
    localparam int unsigned REPEAT_50M   = 12_500_000;  // 0.25 s
    localparam int unsigned CNT_W_DEF    = 26;

endpackage

// File: rtl/key_conditioner_if.sv
// Button bundle between the board pins and the counter/edit logic.
//   key_n    : raw active-low buttons (asynchronous)
//   rep_en   : per-key auto-repeat enable
//   key_evt  : one-cycle press / auto-repeat pulse
//   key_rel  : one-cycle release pulse
//   key_held : debounced pressed level
interface key_conditioner_if
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS = NUM_KEYS_DEF
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] rep_en;
    logic [NUM_KEYS-1:0] key_evt;
    logic [NUM_KEYS-1:0] key_rel;
    logic [NUM_KEYS-1:0] key_held;

    // Driver side (board / testbench).
    modport master (
        output key_n,
        output rep_en,
        input  key_evt,
        input  key_rel,
        input  key_held
    );

    // Conditioner side.
    modport slave (
        input  key_n,
        input  rep_en,
        output key_evt,
        output key_rel,
        output key_held
    );
endinterface

// File: rtl/key_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce/repeat FSM and counter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_key_n      : raw active-low button
//   i_rep_en     : auto-repeat enable
//   o_evt        : press / repeat pulse (registered)
//   o_rel        : release pulse (registered)
//   o_held       : debounced pressed level (registered)
module key_channel
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_50M,
    parameter int unsigned HOLD_CYC     = HOLD_50M,
    parameter int unsigned REPEAT_CYC   = REPEAT_50M,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    input  logic i_rep_en,
    output logic o_evt,
    output logic o_rel,
    output logic o_held
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_evt;
    logic             r_rel;
    logic             r_held;

    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_evt_nxt;
    logic             w_rel_nxt;
    logic             w_held_nxt;
    logic             w_s;

    assign w_s = r_sync2;

    // Synchroniser, state, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
            r_rel   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_evt   <= w_evt_nxt;
            r_rel   <= w_rel_nxt;
            r_held  <= w_held_nxt;
        end
    end

    // Next state, counter and pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_evt_nxt   = 1'b0;
        w_rel_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_s) begin
                    w_state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (w_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_evt_nxt   = 1'b1;
                end
            end
            HELD: begin
                if (w_s) begin
                    w_state_nxt = REL_DB;
                    w_cnt_nxt   = '0;
                end else if (!i_rep_en) begin
                    // Repeat disabled: the hold timer stays parked at zero.
                    w_cnt_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = REPEAT;
                    w_cnt_nxt   = '0;
                    w_evt_nxt   = 1'b1;
                end
            end
            REPEAT: begin
                if (w_s) begin
                    w_state_nxt = REL_DB;
                    w_cnt_nxt   = '0;
                end else if (!i_rep_en) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_nxt = '0;
                    w_evt_nxt = 1'b1;
                end
            end
            REL_DB: begin
                if (!w_s) begin
                    // Release bounce: back to held, hold timer restarts.
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_rel_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Held level follows the next state so it aligns with the evt/rel pulses.
        w_held_nxt = (w_state_nxt == HELD) || (w_state_nxt == REPEAT) ||
                     (w_state_nxt == REL_DB);
    end

    assign o_evt  = r_evt;
    assign o_rel  = r_rel;
    assign o_held = r_held;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: NUM_KEYS independent debounce/auto-repeat channels.
//   clk, rst : clock, synchronous active-high reset
//   kif      : button bundle (slave side): key_n, rep_en in; key_evt,
//              key_rel, key_held out
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = NUM_KEYS_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_50M,
    parameter int unsigned HOLD_CYC     = HOLD_50M,
    parameter int unsigned REPEAT_CYC   = REPEAT_50M,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    key_conditioner_if.slave   kif
);

    localparam int unsigned MAX_DH  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
    localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYC) ? MAX_DH : REPEAT_CYC;

    // Elaboration-time parameter sanity.
    if (DEBOUNCE_CYC < 2) begin : g_bad_db
        $error("key_conditioner: DEBOUNCE_CYC must be >= 2");
    end
    if (HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_rep
        $error("key_conditioner: HOLD_CYC and REPEAT_CYC must be >= 1");
    end
    if (CNT_W < 63 && (64'd1 << CNT_W) <= 64'(MAX_CYC)) begin : g_bad_w
        $error("key_conditioner: CNT_W too narrow for timing parameters");
    end

    // One self-contained channel per key; no interaction between keys.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_key_n  (kif.key_n[g]),
            .i_rep_en (kif.rep_en[g]),
            .o_evt    (kif.key_evt[g]),
            .o_rel    (kif.key_rel[g]),
            .o_held   (kif.key_held[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios with literal
// expectations plus a randomized run against a debounced-level model.
module tb_key_conditioner;

    localparam int unsigned NK = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned HC = 10;
    localparam int unsigned RC = 5;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS     (NK),
        .DEBOUNCE_CYC (DB),
        .HOLD_CYC     (HC),
        .REPEAT_CYC   (RC),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: a key's debounced level flips once the synchronised
    // input has disagreed with it for DB+1 consecutive samples. While pressed
    // and steady, a repeat timer fires after HC then every RC samples.
    logic [NK-1:0] m_p1, m_p2;
    bit   [NK-1:0] m_deb, m_first;
    int            m_run [NK];
    int            m_tim [NK];
    logic [NK-1:0] exp_evt, exp_rel, exp_held;

    always @(posedge clk) begin
        if (rst) begin
            m_p1 = '1; m_p2 = '1; m_deb = '0; m_first = '1;
            exp_evt = '0; exp_rel = '0; exp_held = '0;
            for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_tim[i] = 0; end
        end else begin
            for (int i = 0; i < NK; i++) begin
                logic s;
                s = m_p2[i];
                exp_evt[i] = 1'b0;
                exp_rel[i] = 1'b0;
                if (!m_deb[i]) begin
                    if (!s) begin
                        m_run[i]++;
                        if (m_run[i] == int'(DB) + 1) begin
                            m_deb[i] = 1'b1; m_run[i] = 0; m_tim[i] = 0;
                            m_first[i] = 1'b1; exp_evt[i] = 1'b1;
                        end
                    end else m_run[i] = 0;
                end else if (s) begin
                    m_run[i]++; m_tim[i] = 0; m_first[i] = 1'b1;
                    if (m_run[i] == int'(DB) + 1) begin
                        m_deb[i] = 1'b0; m_run[i] = 0; exp_rel[i] = 1'b1;
                    end
                end else if (m_run[i] > 0 || !kif.rep_en[i]) begin
                    m_run[i] = 0; m_tim[i] = 0; m_first[i] = 1'b1;
                end else begin
                    m_tim[i]++;
                    if (m_tim[i] == (m_first[i] ? int'(HC) : int'(RC))) begin
                        exp_evt[i] = 1'b1; m_tim[i] = 0; m_first[i] = 1'b0;
                    end
                end
                exp_held[i] = m_deb[i];
            end
            m_p2 = m_p1;
            m_p1 = kif.key_n;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vec_cnt++;
            if ({kif.key_evt, kif.key_rel, kif.key_held} !== {exp_evt, exp_rel, exp_held}) begin
                miss_cnt++;
                $display("FAIL model t=%0t: evt/rel/held got %b/%b/%b want %b/%b/%b", $time,
                         kif.key_evt, kif.key_rel, kif.key_held, exp_evt, exp_rel, exp_held);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            miss_cnt++;
            $display("FAIL %s t=%0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask

    // Advance one edge; inputs set before the call are sampled at that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        kif.key_n  = '1;
        kif.rep_en = '0;
        step();
        chk_en = 1'b1;
        idle(2);
        chk("reset_outs", 32'({kif.key_evt, kif.key_rel, kif.key_held}), 32'd0);
        rst = 1'b0;
        idle(3);

        // Clean press and release on key 0.
        for (int j = 0; j < 30; j++) begin
            kif.key_n[0] = 1'b0;
            step();
            chk("press0_evt", 32'(kif.key_evt[0]), 32'(j == 6));
            chk("press0_held", 32'(kif.key_held[0]), 32'(j >= 6));
            chk("press0_others", 32'({kif.key_evt[2:1], kif.key_held[2:1]}), 32'd0);
        end
        for (int j = 0; j < 12; j++) begin
            kif.key_n[0] = 1'b1;
            step();
            chk("rel0_rel", 32'(kif.key_rel[0]), 32'(j == 6));
            chk("rel0_held", 32'(kif.key_held[0]), 32'(j < 6));
        end
        idle(4);

        // Press bounce on key 1: only the steady run from edge 4 counts.
        for (int j = 0; j < 14; j++) begin
            kif.key_n[1] = (j == 3);
            step();
            chk("bounce1_evt", 32'(kif.key_evt[1]), 32'(j == 10));
        end
        kif.key_n[1] = 1'b1;
        idle(12);

        // Auto-repeat on key 2, then the same hold with repeat disabled.
        for (int pass = 0; pass < 2; pass++) begin
            kif.rep_en[2] = (pass == 0);
            for (int j = 0; j < 40; j++) begin
                logic want;
                kif.key_n[2] = 1'b0;
                step();
                want = (j == 6) || (pass == 0 && (j == 16 || j == 21 || j == 26 ||
                                                 j == 31 || j == 36));
                chk("repeat2_evt", 32'(kif.key_evt[2]), 32'(want));
            end
            kif.key_n[2] = 1'b1;
            idle(12);
        end
        kif.rep_en[2] = 1'b0;

        // Release bounce on key 0: high 2, low 1, then steady high from edge 3.
        kif.key_n[0] = 1'b0;
        idle(15);
        for (int j = 0; j < 14; j++) begin
            kif.key_n[0] = (j != 2);
            step();
            chk("relb0_rel", 32'(kif.key_rel[0]), 32'(j == 9));
            chk("relb0_held", 32'(kif.key_held[0]), 32'(j < 9));
            chk("relb0_evt", 32'(kif.key_evt[0]), 32'd0);
        end
        idle(4);

        // Reset in the middle of auto-repeat, key kept down throughout.
        kif.rep_en[2] = 1'b1;
        kif.key_n[2]  = 1'b0;
        idle(25);
        chk("pre_rst_held", 32'(kif.key_held[2]), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_outs", 32'({kif.key_evt, kif.key_rel, kif.key_held}), 32'd0);
        step();
        rst = 1'b0;
        for (int j = 0; j < 9; j++) begin
            step();
            chk("post_rst_evt", 32'(kif.key_evt[2]), 32'(j == 6));
        end
        kif.key_n[2]  = 1'b1;
        kif.rep_en[2] = 1'b0;
        idle(12);

        // Simultaneous presses on keys 0 and 2.
        for (int j = 0; j < 9; j++) begin
            kif.key_n[0] = 1'b0;
            kif.key_n[2] = 1'b0;
            step();
            chk("simul_evt", 32'({kif.key_evt[2], kif.key_evt[1], kif.key_evt[0]}),
                (j == 6) ? 32'h5 : 32'h0);
        end
        kif.key_n = '1;
        idle(12);

        // Randomized run: bouncy buttons, toggling repeat enables, rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(0, 9) == 0) kif.key_n[i] = ~kif.key_n[i];
                if ($urandom_range(0, 59) == 0) kif.rep_en[i] = ~kif.rep_en[i];
            end
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        kif.key_n = '1;
        idle(12);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
